// File: rtl/pvt_monitor_pkg.sv
// Shared constants and types for the PVT monitor clock-to-Q / setup readout.
package pvt_monitor_pkg;

    // Default geometry of the measurement.
    localparam int DEF_CNT_WIDTH = 8;
    localparam int DEF_LAPS      = 4;
    localparam int DEF_TIMEOUT   = 255;

    // Lap counter is sized for the largest supported lap count (15).
    localparam int LAP_W = 4;

    // Measurement sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_ARM    = 3'd2,
        ST_RUN    = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Bits needed to hold values 0..max_val.
    function automatic int cnt_bits(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/lap_edge_detect.sv
// Rising-edge detector for the delay-chain ring token, with a synchronous
// clear of the history so a fresh measurement never sees a stale edge.
module lap_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic in,
    output logic rise
);

    logic prev;

    // Remember last cycle's token level; clear forces "was low".
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev <= 1'b0;
        end else if (clear) begin
            prev <= 1'b0;
        end else begin
            prev <= in;
        end
    end

    assign rise = in & ~prev;

endmodule

// File: rtl/clkq_setup_readout.sv
// Measurement sequencer: launches the delay-chain measurer, counts token laps,
// and reports the elapsed measurer-counter ticks (or a timeout) to the host.
module clkq_setup_readout
    import pvt_monitor_pkg::*;
#(
    parameter int CNT_WIDTH = DEF_CNT_WIDTH,
    parameter int LAPS      = DEF_LAPS,
    parameter int TIMEOUT   = DEF_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req,
    output logic                 start,
    input  logic                 token,
    input  logic [CNT_WIDTH-1:0] measured_cnt,
    output logic [CNT_WIDTH-1:0] result_cnt,
    output logic                 result_valid,
    input  logic                 result_ready,
    output logic                 timeout_err,
    output logic                 busy
);

    localparam int                CYC_W    = cnt_bits(TIMEOUT);
    localparam logic [LAP_W-1:0]  LAST_LAP = LAP_W'(LAPS - 1);
    localparam logic [CYC_W-1:0]  LAST_CYC = CYC_W'(TIMEOUT - 1);

    state_t                 state;
    state_t                 state_next;
    logic [CNT_WIDTH-1:0]   cnt_start;
    logic [LAP_W-1:0]       lap_cnt;
    logic [CYC_W-1:0]       cyc_cnt;
    logic                   tok_rise;
    logic                   in_run;
    logic                   final_edge;
    logic                   timeout_hit;

    lap_edge_detect u_lap_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (state == ST_ARM),
        .in    (token),
        .rise  (tok_rise)
    );

    assign in_run      = (state == ST_RUN);
    // Final lap edge takes priority over a timeout landing in the same cycle.
    assign final_edge  = in_run && tok_rise && (lap_cnt == LAST_LAP);
    assign timeout_hit = in_run && (cyc_cnt == LAST_CYC);

    // Next-state decode for the measurement sequence.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_next unassigned (no latch).
        state_next = state;
        unique case (state)
            ST_IDLE:   if (req) state_next = ST_LAUNCH;
            ST_LAUNCH: state_next = ST_ARM;
            ST_ARM:    state_next = ST_RUN;
            ST_RUN:    if (final_edge || timeout_hit) state_next = ST_DONE;
            ST_DONE:   if (result_ready) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // State register and registered status outputs derived from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            start        <= 1'b0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_next;
            start        <= (state_next == ST_LAUNCH);
            result_valid <= (state_next == ST_DONE);
            busy         <= (state_next != ST_IDLE);
        end
    end

    // Snapshot of the measurer counter taken in the launch cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_start <= '0;
        end else if (state == ST_LAUNCH) begin
            cnt_start <= measured_cnt;
        end
    end

    // Lap and cycle counters: cleared in ARM, advanced only while running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lap_cnt <= '0;
            cyc_cnt <= '0;
        end else if (state == ST_ARM) begin
            lap_cnt <= '0;
            cyc_cnt <= '0;
        end else if (in_run) begin
            cyc_cnt <= cyc_cnt + 1'b1;
            if (tok_rise) begin
                lap_cnt <= lap_cnt + 1'b1;
            end
        end
    end

    // Result capture: elapsed ticks wrap modulo 2^CNT_WIDTH; timeout reports zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_cnt  <= '0;
            timeout_err <= 1'b0;
        end else if (final_edge) begin
            result_cnt  <= measured_cnt - cnt_start;
            timeout_err <= 1'b0;
        end else if (timeout_hit) begin
            result_cnt  <= '0;
            timeout_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_clkq_setup_readout.sv
// Bench for clkq_setup_readout: ring model pulses the token one cycle every
// 16 cycles after start; the measurer counter free-runs. A second instance
// with TIMEOUT=63 lands its timeout on the same cycle as the final lap edge.
module tb_clkq_setup_readout;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req = 1'b0;
    logic       token = 1'b0;
    logic       result_ready = 1'b0;
    logic [7:0] meas = 8'd0;

    logic       start0, rv0, te0, busy0;
    logic [7:0] rc0;
    logic       start1, rv1, te1, busy1;
    logic [7:0] rc1;

    int n_checks = 0;
    int n_fail   = 0;

    int ring_age = 0;
    bit ring_on  = 1'b0;
    bit tok_hold = 1'b0;

    always #5 clk = ~clk;

    clkq_setup_readout dut0 (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .start        (start0),
        .token        (token),
        .measured_cnt (meas),
        .result_cnt   (rc0),
        .result_valid (rv0),
        .result_ready (result_ready),
        .timeout_err  (te0),
        .busy         (busy0)
    );

    clkq_setup_readout #(.TIMEOUT(63)) dut1 (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .start        (start1),
        .token        (token),
        .measured_cnt (meas),
        .result_cnt   (rc1),
        .result_valid (rv1),
        .result_ready (result_ready),
        .timeout_err  (te1),
        .busy         (busy1)
    );

    typedef struct {
        logic [7:0] launch;     // measurer counter value in the LAUNCH cycle
        bit         hold_tok;   // token stuck low
        int         hold_cyc;   // cycles to stall result_ready in DONE
        logic [7:0] exp_cnt0;
        bit         exp_te0;
        int         exp_age0;   // cycles after LAUNCH when result_valid rises
        logic [7:0] exp_cnt1;
        bit         exp_te1;
        int         exp_age1;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: advance the counter and the ring model just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        meas = meas + 8'd1;
        if (start0) begin
            ring_on  = 1'b1;
            ring_age = 0;
        end else if (ring_on) begin
            ring_age++;
        end
        token = ring_on && !tok_hold && (ring_age > 0) && (ring_age % 16 == 0);
    endtask

    task automatic run_vec(input vec_t v);
        bit         seen0, seen1;
        int         age1;
        logic [7:0] cnt1;
        logic       te1_s;
        seen0 = 1'b0;
        seen1 = 1'b0;
        age1  = -1;
        cnt1  = 8'd0;
        te1_s = 1'b0;
        tok_hold = v.hold_tok;
        meas = v.launch - 8'd1;
        req  = 1'b1;
        check("start_low_before_req", start0, 1'b0);
        tick();
        req = 1'b0;
        check("start_after_req", start0, 1'b1);
        check("busy_in_launch", busy0, 1'b1);
        for (int i = 0; i < 400; i++) begin
            tick();
            if (i == 0) check("start_one_cycle", start0, 1'b0);
            if (rv1 && !seen1) begin
                seen1 = 1'b1;
                age1  = ring_age;
                cnt1  = rc1;
                te1_s = te1;
            end
            if (rv0) begin
                seen0 = 1'b1;
                break;
            end
        end
        check("valid_seen", seen0, 1'b1);
        check("valid_latency", ring_age, v.exp_age0);
        check("result_cnt", rc0, v.exp_cnt0);
        check("timeout_err", te0, v.exp_te0);
        check("coinc_valid_seen", seen1, 1'b1);
        check("coinc_latency", age1, v.exp_age1);
        check("coinc_result_cnt", cnt1, v.exp_cnt1);
        check("coinc_timeout_err", te1_s, v.exp_te1);
        for (int i = 0; i < v.hold_cyc; i++) begin
            req = i[0];
            tick();
            check("hold_valid", rv0, 1'b1);
            check("hold_cnt", rc0, v.exp_cnt0);
            check("hold_busy", busy0, 1'b1);
            check("hold_no_start", start0, 1'b0);
        end
        // Accept with req also high: that req must not be sampled.
        result_ready = 1'b1;
        req = 1'b1;
        tick();
        result_ready = 1'b0;
        req = 1'b0;
        check("accept_valid_low", rv0, 1'b0);
        check("accept_busy_low", busy0, 1'b0);
        tick();
        check("accept_req_ignored", start0, 1'b0);
        check("idle_stays", busy0, 1'b0);
        tok_hold = 1'b0;
    endtask

    initial begin
        int stray;
        vecs[0] = '{8'd10,  1'b0, 20, 8'd64, 1'b0, 65,  8'd64, 1'b0, 65};
        vecs[1] = '{8'd250, 1'b0, 0,  8'd64, 1'b0, 65,  8'd64, 1'b0, 65};
        vecs[2] = '{8'd0,   1'b1, 0,  8'd0,  1'b1, 257, 8'd0,  1'b1, 65};
        vecs[3] = '{8'd200, 1'b0, 0,  8'd64, 1'b0, 65,  8'd64, 1'b0, 65};

        // Reset state.
        tick();
        tick();
        check("rst_start", start0, 1'b0);
        check("rst_valid", rv0, 1'b0);
        check("rst_cnt", rc0, 8'd0);
        check("rst_terr", te0, 1'b0);
        check("rst_busy", busy0, 1'b0);
        rst_n = 1'b1;
        tick();
        tick();
        check("idle_no_start", start0, 1'b0);

        foreach (vecs[k]) run_vec(vecs[k]);

        // Reset in RUN after two laps: outputs clear at once, nothing afterwards.
        meas = 8'd99;
        req  = 1'b1;
        tick();
        req = 1'b0;
        for (int i = 0; i < 100 && ring_age < 40; i++) tick();
        check("mid_run_busy", busy0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_start", start0, 1'b0);
        check("async_rst_valid", rv0, 1'b0);
        check("async_rst_cnt", rc0, 8'd0);
        check("async_rst_terr", te0, 1'b0);
        check("async_rst_busy", busy0, 1'b0);
        ring_on = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        stray = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (rv0 || rv1 || start0 || busy0) stray++;
        end
        check("no_result_after_reset", stray, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clkq_setup_readout.md
CLKQ_SETUP_READOUT -- requirements
Module: clkq_setup_readout

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 8, width of the measurement counter and result.
REQ-002 SHALL have parameter LAPS, default 4, number of token laps per measurement (1..15).
REQ-003 SHALL have parameter TIMEOUT, default 255, maximum cycles in RUN before abort (< 2^CNT_WIDTH... 2^12).
REQ-004 SHALL have port clk, input, 1, single clock for all logic.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port req, input, 1, host measurement request, sampled only in IDLE.
REQ-007 SHALL have port start, output, 1, one-cycle launch pulse to the delay-chain measurer.
REQ-008 SHALL have port token, input, 1, last-stage tap of the delay-chain ring.
REQ-009 SHALL have port measured_cnt, input, CNT_WIDTH, free-running counter from the measurer.
REQ-010 SHALL have port result_cnt, output, CNT_WIDTH, elapsed counter ticks over LAPS laps.
REQ-011 SHALL have port result_valid, output, 1, result available; held until accepted.
REQ-012 SHALL have port result_ready, input, 1, host accepts result when high with result_valid.
REQ-013 SHALL have port timeout_err, output, 1, qualifies result_valid; set when the measurement aborted.
REQ-014 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-015 SHALL implement states IDLE, LAUNCH, ARM, RUN, DONE.
REQ-016 IDLE -> LAUNCH on req=1; otherwise stay.
REQ-017 LAUNCH SHALL drive start=1 for exactly one cycle and capture cnt_start <= measured_cnt in that cycle; -> ARM.
REQ-018 ARM SHALL last one cycle, clear lap counter, cycle counter and token-edge history; -> RUN.
REQ-019 RUN SHALL count token rising edges (token=1 and previous-cycle token=0); edges in LAUNCH/ARM are ignored.
REQ-020 On the LAPS-th rising edge, SHALL capture result_cnt <= (measured_cnt - cnt_start) mod 2^CNT_WIDTH, timeout_err <= 0; -> DONE.
REQ-021 RUN SHALL count cycles; when count reaches TIMEOUT without the final edge, result_cnt <= 0, timeout_err <= 1; -> DONE.
REQ-022 Final edge and timeout in the same cycle: final edge wins (valid result, timeout_err=0).
REQ-023 DONE SHALL assert result_valid with result_cnt and timeout_err stable; -> IDLE on result_ready=1.
REQ-024 req is ignored outside IDLE; req in the DONE-accept cycle is not sampled (host re-asserts in IDLE).
REQ-025 Subtraction SHALL wrap modulo 2^CNT_WIDTH with no overflow flag; LAPS*lap period < 2^CNT_WIDTH is a usage constraint.
REQ-026 start SHALL be registered (glitch-free), low in all states except LAUNCH.

Reset
REQ-027 On rst_n=0, asynchronously: state=IDLE, start=0, result_valid=0, result_cnt=0, timeout_err=0, busy=0, all internal counters and token history cleared.
REQ-028 Reset mid-measurement SHALL abandon it with no result_valid produced after release.

Structure
REQ-029 State enum and default CNT_WIDTH/LAPS/TIMEOUT constants SHALL live in shared package pvt_monitor_pkg.
REQ-030 Token rising-edge detection SHALL be a sub-module lap_edge_detect (clk, rst_n, clear, in, rise).

Verification (bench model: ring token high one cycle every 16 cycles after start, counter free-running)
REQ-031 req pulse, cnt_start=10, LAPS=4 -> start one cycle after req, result_valid with result_cnt=64, timeout_err=0.
REQ-032 cnt_start=250, LAPS=4 -> result_cnt=64 (wrap: end value 58).
REQ-033 token held 0, TIMEOUT=255 -> result_valid 255 cycles after RUN entry, result_cnt=0, timeout_err=1.
REQ-034 result_ready=0 for 20 cycles in DONE -> result_valid and result_cnt stable; req pulses in that window ignored; ready=1 -> IDLE next cycle.
REQ-035 rst_n low during RUN after 2 laps -> all outputs 0 immediately; after release no result_valid without new req.
REQ-036 final token edge coinciding with timeout cycle -> result valid, timeout_err=0.
